data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, meaning memory access cycles, legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port p_req, p_we, p_addr, p_wdata, all inputs (1, 1, ADDR_WIDTH, DATA_WIDTH bits): pipeline MEM-stage request, write enable, address and write data.
REQ-007 The block SHALL have port p_rdata, output, DATA_WIDTH: pipeline read data.
REQ-008 The block SHALL have port p_ack, output, 1 bit: pipeline completion pulse.
REQ-009 The block SHALL have port stall, output, 1 bit: freeze request to the pipeline registers.
REQ-010 The block SHALL have port d_req, d_we, d_addr, d_wdata, all inputs (1, 1, ADDR_WIDTH, DATA_WIDTH bits): loader/DMA request, write enable, address and write data.
REQ-011 The block SHALL have port d_rdata, output, DATA_WIDTH: loader read data.
REQ-012 The block SHALL have port d_ack, output, 1 bit: loader completion pulse.
REQ-013 The block SHALL have ports mem_en, mem_we, mem_addr, mem_wdata, all outputs (1, 1, ADDR_WIDTH, DATA_WIDTH bits): shared single-port data memory controls.
REQ-014 The block SHALL have port mem_rdata, input, DATA_WIDTH: shared memory read data.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-017 In IDLE with any req high, the FSM SHALL latch the grant, we, addr and wdata of the winner and go to ACCESS at the next edge.
REQ-018 In ACCESS, mem_en SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL carry the latched values, for exactly WAIT_STATES cycles, counted by a 4-bit down-counter.
REQ-019 On the last ACCESS cycle the block SHALL register mem_rdata into the granted requester's rdata register (reads only), then go to DONE.
REQ-020 In DONE the granted ack SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; the non-granted ack SHALL remain 0.
REQ-021 Request-to-ack latency SHALL be WAIT_STATES+1 cycles, and the minimum back-to-back period SHALL be WAIT_STATES+2 cycles.
REQ-022 rdata outputs SHALL hold their value until the next read completion for the same requester; writes SHALL leave rdata unchanged.
REQ-023 A requester SHALL hold req, we, addr and wdata stable until it sees ack; req sampled high in IDLE is a new request.
REQ-024 Request inputs changing during ACCESS or DONE SHALL NOT affect the access in progress.
REQ-025 stall SHALL be combinational, equal to p_req AND NOT (state==DONE AND grant==pipeline).
REQ-026 mem_we SHALL never be 1 while mem_en is 0.
REQ-027 In IDLE with no request, mem_en SHALL be 0 and the FSM SHALL stay in IDLE.

Reset
REQ-028 On reset low, the block SHALL asynchronously enter IDLE.
REQ-029 On reset low, all outputs SHALL go to 0, rdata registers SHALL clear to 0, and the round-robin pointer SHALL become "loader last".
REQ-030 Reset asserted mid-ACCESS SHALL abandon the access with no ack issued and no further memory strobe.

Configuration
REQ-031 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last, and the pointer SHALL update on every grant.
REQ-032 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to the pipeline (fixed priority), and no pointer register SHALL exist.

Verification
REQ-033 WAIT_STATES=1: pipeline write of 0xDEADBEEF to address 0x10 -> mem_en and mem_we high for 1 cycle with addr 0x10; p_ack pulses at cycle 2; stall high in cycles 0-1.
REQ-034 WAIT_STATES=3: loader read of 0x20 with mem_rdata=0x12345678 -> d_ack at cycle 4; d_rdata=0x12345678; p_rdata unchanged.
REQ-035 p_req and d_req both raised in the same cycle (round robin on) -> pipeline is served first and loader second, and the next simultaneous pair is pipeline first again; with the macro off, the pipeline always wins.
REQ-036 reset driven low during cycle 1 of a 3-cycle ACCESS -> mem_en drops immediately, no ack ever appears, and busy=0.
REQ-037 p_addr changed to 0x44 mid-ACCESS of a 0x40 access -> mem_addr stays 0x40 until DONE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates a pipeline MEM stage and a loader/DMA port onto one
// single-port data memory with a fixed number of wait states.
// Ports:
//   clk, reset (async, active-low)
//   p_req/p_we/p_addr/p_wdata -> p_rdata/p_ack/stall : pipeline port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack       : loader port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata       : shared memory
//   busy                                              : FSM not idle
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests;
// otherwise the pipeline has fixed priority.
module data_mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_req,
    input  logic                  p_we,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0] p_wdata,
    output logic [DATA_WIDTH-1:0] p_rdata,
    output logic                  p_ack,
    output logic                  stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nx;
    logic                  grant;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt;
    logic                  win;
    logic                  start;
    logic                  last_cyc;

    assign start    = state == IDLE && (p_req || d_req);
    assign last_cyc = state == ACCESS && cnt == 4'd1;

    // win = 1 selects the loader
`ifdef ARB_ROUND_ROBIN_EN
    logic last_ld;
    assign win = d_req && (!p_req || !last_ld);
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_ld <= 1'b1;
        else if (start) last_ld <= win;
`else
    assign win = d_req && !p_req;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == ACCESS ? (cnt == 4'd1 ? DONE : ACCESS) : start ? ACCESS : IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            grant   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            p_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (start) begin
                grant   <= win;
                we_q    <= win ? d_we : p_we;
                addr_q  <= win ? d_addr : p_addr;
                wdata_q <= win ? d_wdata : p_wdata;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == ACCESS) cnt <= cnt - 4'd1;
            if (last_cyc && !we_q && !grant) p_rdata <= mem_rdata;
            if (last_cyc && !we_q && grant) d_rdata <= mem_rdata;
        end

    assign mem_en    = state == ACCESS;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p_ack     = state == DONE && !grant;
    assign d_ack     = state == DONE && grant;
    assign busy      = state != IDLE;
    assign stall     = p_req && !p_ack;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized scoreboard bench for data_mem_arbiter (WAIT_STATES=3).
module tb_data_mem_arbiter;
    localparam int WS = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 0, reset = 0;
    logic p_req = 0, p_we = 0, d_req = 0, d_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic p_ack, d_ack, stall, mem_en, mem_we, busy;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] rd_reg [2];
    bit last_ld = 1;
    int cyc = 0, vectors = 0, miscompares = 0;
    typedef struct {
        bit who;
        bit we;
        logic [31:0] addr, wdata, ep, ed;
        int ack_cyc;
    } txn_t;
    txn_t sb[$];

    data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ack(p_ack), .stall(stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[7:2]];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle, compare the DUT against the timeline of the oldest queued access.
    always @(negedge clk) begin : mon
        bit act, in_acc, at_ack;
        txn_t t;
        if (reset) begin
            act = sb.size() > 0;
            if (act) t = sb[0];
            in_acc = act && cyc >= t.ack_cyc - WS && cyc < t.ack_cyc;
            at_ack = act && cyc == t.ack_cyc;
            chk1("stall", stall, p_req && !(at_ack && !t.who));
            chk1("mem_en", mem_en, in_acc);
            chk1("busy", busy, act && cyc >= t.ack_cyc - WS && cyc <= t.ack_cyc);
            chk1("p_ack", p_ack, at_ack && !t.who);
            chk1("d_ack", d_ack, at_ack && t.who);
            if (!mem_en) chk1("mem_we_idle", mem_we, 1'b0);
            if (in_acc && mem_en) begin
                chk("mem_addr", mem_addr, t.addr);
                chk1("mem_we", mem_we, t.we);
                if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
            end
            if (at_ack) begin
                chk("p_rdata", p_rdata, t.ep);
                chk("d_rdata", d_rdata, t.ed);
            end
            if (act && cyc >= t.ack_cyc) void'(sb.pop_front());
        end
    end

    // Issue one arbitration round at the current (idle) cycle and hold requests until each ack.
    task automatic round(bit pr, bit dr, bit pwe, bit dwe, logic [31:0] pa, logic [31:0] pw,
                         logic [31:0] da, logic [31:0] dw, bit chg);
        bit d_first, who, we;
        int t0, n, pc, dc, last;
        logic [31:0] a, w;
        t0 = cyc;
        d_first = (pr && dr) ? (RR && !last_ld) : dr;
        n = int'(pr) + int'(dr);
        for (int k = 0; k < n; k++) begin
            who = k == 0 ? d_first : !d_first;
            we = who ? dwe : pwe;
            a = who ? da : pa;
            w = who ? dw : pw;
            if (we) ref_mem[a[7:2]] = w;
            else rd_reg[who] = ref_mem[a[7:2]];
            last_ld = who;
            sb.push_back('{who, we, a, w, rd_reg[0], rd_reg[1], t0 + WS + 1 + k * (WS + 2)});
        end
        pc = t0 + WS + 1 + (d_first ? WS + 2 : 0);
        dc = t0 + WS + 1 + (d_first ? 0 : WS + 2);
        last = t0 + WS + 1 + (n - 1) * (WS + 2);
        p_req = pr; p_we = pwe; p_addr = pa; p_wdata = pw;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        #1 chk1("stall_issue", stall, pr);
        while (cyc < last) begin
            @(negedge clk); #1;
            if (chg && cyc == t0 + 1) p_addr = pa + 32'h4;
            if (pr && cyc == pc) p_req = 0;
            if (dr && cyc == dc) d_req = 0;
        end
        @(negedge clk); #1;
    endtask

    task automatic reset_mid_access();
        int t0;
        t0 = cyc;
        sb.push_back('{1'b0, 1'b0, 32'h30, 32'h0, rd_reg[0], rd_reg[1], t0 + WS + 1});
        p_req = 1; p_we = 0; p_addr = 32'h30;
        @(negedge clk); #1;
        reset = 0;
        #1;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_p_ack", p_ack, 1'b0);
        chk("rst_p_rdata", p_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        sb.delete();
        rd_reg[0] = 0; rd_reg[1] = 0; last_ld = 1;
        p_req = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1;
        repeat (WS + 3) begin
            @(negedge clk); #1;
            chk1("no_ack_after_rst", p_ack || d_ack, 1'b0);
            chk1("no_en_after_rst", mem_en, 1'b0);
        end
    endtask

    task automatic rand_round();
        int sel;
        sel = $urandom_range(1, 3);
        repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        round(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
              {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8] = 32'h12345678;
        ref_mem[8] = 32'h12345678;
        rd_reg[0] = 0; rd_reg[1] = 0;
        #1;
        chk1("reset_mem_en", mem_en, 1'b0);
        chk1("reset_mem_we", mem_we, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_p_ack", p_ack, 1'b0);
        chk1("reset_d_ack", d_ack, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        chk("reset_p_rdata", p_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1;
        @(negedge clk); #1;
        round(1, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        chk("mem_0x10", mem[4], 32'hDEADBEEF);
        round(0, 1, 0, 0, 0, 0, 32'h20, 0, 0);
        chk("d_rdata_0x20", d_rdata, 32'h12345678);
        chk("p_rdata_kept", p_rdata, 32'h0);
        round(1, 1, 0, 0, 32'h20, 0, 32'h10, 0, 0);
        round(1, 1, 1, 0, 32'h80, 32'hCAFEF00D, 32'h80, 0, 0);
        round(1, 0, 0, 0, 32'h40, 0, 0, 0, 1);
        repeat (150) rand_round();
        reset_mid_access();
        repeat (30) rand_round();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
